// File: rtl/hra_pkg.sv
// Shared types for the hold/release arbiter.
//   state_e : arbiter sequencer states
//   cause_e : encoding of release_cause (why a grant ended)
package hra_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_DONE,
    CAUSE_ABORT,
    CAUSE_TMO
  } cause_e;

endpackage

// File: rtl/hold_release_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req   [NUM_REQ-1:0] : request vector
//   ptr   [IDX_W-1:0]   : index with highest priority this pick
//   valid               : at least one request is set
//   idx   [IDX_W-1:0]   : first set request found scanning up from ptr (wrapping)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int j;

  // Scan from the farthest offset down to ptr itself so the closest
  // requester (in rotated order) is the last one written and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/hold_release_arbiter.sv
// hold_release_arbiter: round-robin arbiter that holds a grant until a
// release event (done, abort or hold-timer expiry), then forces an idle gap.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   req           : level request per requester
//   done, abort   : release events from the current owner
//   timeout_val   : maximum grant length in cycles (0 = no timeout), sampled at grant start
//   gnt           : one-hot grant (or zero)
//   gnt_id        : index of current / last owner
//   busy          : any grant active
//   released      : one-cycle pulse when a grant ends
//   release_cause : hra_pkg::cause_e, valid with released
//   timeout_err   : sticky flag, set by a timeout release
module hold_release_arbiter
  import hra_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int TMO_W      = 8,
  parameter  int GAP_CYCLES = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               abort,
  input  logic [TMO_W-1:0]   timeout_val,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               released,
  output logic [1:0]         release_cause,
  output logic               timeout_err
);

  // The released cycle is itself the first gap cycle, hence the -1.
  localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 released_q, released_d;
  cause_e               cause_q, cause_d;
  logic                 terr_q, terr_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           gap_q, gap_d;

  logic                 pick_vld;
  logic [ID_W-1:0]      pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    released_d = 1'b0;
    cause_d    = CAUSE_NONE;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          ptr_d           = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          cnt_d           = timeout_val;
        end
      end

      GRANT: begin
        // Counter parks at 0, so a zero load never produces a timeout.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TMO_W'(1);
        end
        // cnt_q == 1 marks the last permitted grant cycle.
        if (done) begin
          cause_d = CAUSE_DONE;
        end else if (abort) begin
          cause_d = CAUSE_ABORT;
        end else if (cnt_q == TMO_W'(1)) begin
          cause_d = CAUSE_TMO;
        end
        if (cause_d != CAUSE_NONE) begin
          released_d = 1'b1;
          gnt_d      = '0;
          gap_d      = GAP_LOAD;
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
          if (cause_d == CAUSE_TMO) begin
            terr_d = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      released_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      released_q <= released_d;
      cause_q    <= cause_d;
      terr_q     <= terr_d;
    end
  end

  // Counters are only read in the state that loads them; no reset needed.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    gap_q <= gap_d;
  end

  assign gnt           = gnt_q;
  assign gnt_id        = gnt_id_q;
  assign busy          = |gnt_q;
  assign released      = released_q;
  assign release_cause = cause_q;
  assign timeout_err   = terr_q;

endmodule
